// File: rtl/booth_mul32.sv
// booth_mul32: sequential signed 32x32 radix-2 Booth multiplier, one step per clock.
module booth_mul32 (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [31:0] RegA,
  input  logic [31:0] RegB,
  output logic [63:0] Z,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state_q, state_d;
  logic [32:0] a_q, a_d, m_q, m_d, a_add;
  logic [31:0] q_q, q_d;
  logic        q1_q, q1_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] z_q, z_d;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    m_d = m_q;
    q_d = q_q;
    q1_d = q1_q;
    cnt_d = cnt_q;
    z_d = z_q;
    a_add = ({q_q[0], q1_q} == 2'b01) ? a_q + m_q :
            ({q_q[0], q1_q} == 2'b10) ? a_q - m_q : a_q;
    case (state_q)
      IDLE: if (start) begin
        a_d = '0;
        m_d = {RegB[31], RegB};
        q_d = RegA;
        q1_d = 1'b0;
        cnt_d = '0;
        state_d = RUN;
      end
      RUN: begin
        a_d = {a_add[32], a_add[32:1]};
        q_d = {a_add[0], q_q[31:1]};
        q1_d = q_q[0];
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = DONE;
          z_d = {a_d[31:0], q_d};
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      a_q <= '0;
      m_q <= '0;
      q_q <= '0;
      q1_q <= 1'b0;
      cnt_q <= '0;
      z_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      m_q <= m_d;
      q_q <= q_d;
      q1_q <= q1_d;
      cnt_q <= cnt_d;
      z_q <= z_d;
    end
  end
  assign Z = z_q;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
endmodule

// File: doc/booth_mul32.md
# booth_mul32

Sequential signed 32x32 multiplier using radix-2 Booth recoding, producing a 64-bit product on the same `Z` bus layout the ALU datapath uses for divide results. It is the inverse-direction companion to the divider: operands come from `RegA`/`RegB`, and the result is written to the HI/LO pair. It runs one Booth step per clock with a start/busy/done handshake, so the control unit stalls on `busy` instead of relying on a long combinational path.

## Interface
- No parameters; width is fixed at 32-bit operands and a 64-bit product.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `clr`  in  1  synchronous, active-high reset.
- `start`  in  1  request a multiply; sampled only in IDLE.
- `RegA`  in  32  multiplier, two's complement; captured on the accepted `start`.
- `RegB`  in  32  multiplicand, two's complement; captured on the accepted `start`.
- `Z`  out  64  signed product `RegA*RegB`; `Z[63:32]` goes to HI and `Z[31:0]` to LO.
- `busy`  out  1  high from the cycle after an accepted `start` through the DONE cycle.
- `done`  out  1  one-cycle pulse when `Z` holds a new result.

## Operation
- Internal state:
  - `A[32:0]`: partial-product accumulator, 33 bits so subtracting M = -2^31 cannot overflow.
  - `Q[31:0]`: multiplier, shifted right.
  - `q_1`: Booth guard bit.
  - `M[32:0]`: `RegB` sign-extended.
  - `cnt[5:0]`: step counter.
- IDLE:
  - If `start`=1, load `Q`=`RegA`, `M`={`RegB[31]`,`RegB`}, `A`=0, `q_1`=0, `cnt`=0, then go to RUN.
  - Otherwise hold all state.
- RUN, one Booth step per cycle:
  - Decode {`Q[0]`,`q_1`}: 00 or 11 leaves A unchanged, 01 sets A=A+M, 10 sets A=A-M. All arithmetic is 33-bit, discarding the carry out.
  - Then arithmetic-shift {A',Q,q_1} right by one. A'[32] is replicated into the top bit; the old `Q[0]` moves into `q_1`.
  - Increment `cnt`. When `cnt`=31 is being executed (the 32nd step), go to DONE.
- DONE:
  - Register `Z` = {A[31:0], Q} from the post-step values, assert `done`, then go to IDLE.
- `Z` updates only on entry to DONE. It holds the last product until the next completion.
- `start` in RUN or DONE is ignored. It is not queued.
- Results are exact for all 2^64 operand pairs; the 64-bit product never overflows.

## Timing
- Reset values: `Z`=0, `busy`=0, `done`=0, state IDLE, `cnt`=0, A/Q/M/`q_1` cleared.
- `clr` wins over every other event, including `start` in the same cycle. Asserting it mid-RUN aborts the operation, and `done` never pulses for that operation.
- Edge 0 (start accepted): operands are latched and `busy` rises after this edge.
- Edges 1..32: the 32 Booth steps.
- Edge 33: `Z` is valid and `done`=1 for exactly one cycle while `busy` is still 1.
- Edge 34: back in IDLE, `busy`=0, `done`=0.
- Latency from the `start` edge to the `done` cycle is 33 cycles. The earliest next accepted `start` is at edge 34, giving one result every 34 cycles.
- Changing `RegA`/`RegB` after edge 0 has no effect on the result in progress.

## Test plan
- 7 × 6: `RegA`=7, `RegB`=6, pulse `start` -> `done` on cycle 33, `Z`=0x0000_0000_0000_002A, `busy` high for cycles 1–33.
- Signs: `RegA`=0xFFFF_FFFF (-1), `RegB`=1 -> `Z`=0xFFFF_FFFF_FFFF_FFFF. Then `RegA`=-3, `RegB`=-5 -> `Z`=0x0000_0000_0000_000F.
- Extremes:
  - 0x8000_0000 × 0x8000_0000 -> `Z`=0x4000_0000_0000_0000.
  - 0x7FFF_FFFF × 0x8000_0000 -> `Z`=0xC000_0000_8000_0000.
  - 0 × 0x8000_0000 -> `Z`=0.
- Handshake:
  - Hold `start`=1 and change operands during RUN -> one `done` only, with `Z` from the original operands.
  - Assert `start` in the DONE cycle -> ignored.
  - Assert `start` at edge 34 -> accepted.
- Reset:
  - Assert `clr` at cycle 15 of RUN -> next cycle `busy`=0, `done`=0, `Z`=0, and no `done` appears within 40 cycles.
  - `clr` and `start` asserted together -> stays in IDLE.
- Random cross-check: 10k random signed pairs compared against a 64-bit signed reference model. For nonzero `RegB`, also feed `Z[31:0]` into the divider as dividend with divisor `RegB`, restricted to non-negative operands with `Z[63:32]`=0. It must return quotient `RegA` and remainder 0.
